// File: rtl/ysyx_25040118_mem_arb.sv
// Round-robin arbiter sharing one memory port between the IFU and the LSU.
// One transaction in flight; out-of-range addresses and timeouts are answered locally with err=1.
module ysyx_25040118_mem_arb #(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;   // 1 = LSU owns the transaction
  logic               last_q, last_d;     // 1 = LSU was granted last
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;     // already rebased to the memory window
  logic               wen_q, wen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic        ifu_grant, lsu_grant, in_range, expired;
  logic [31:0] req_off, err_rdata;

  // Round-robin tie break: whoever was not granted last wins.
  assign ifu_grant = (state_q == S_IDLE) && ifu_req_valid && (!lsu_req_valid || last_q);
  assign lsu_grant = (state_q == S_IDLE) && lsu_req_valid && (!ifu_req_valid || !last_q);
  assign req_off   = (lsu_grant ? lsu_addr : ifu_addr) - MEM_BASE;
  assign in_range  = req_off < MEM_SIZE;
  assign expired   = cnt_q >= CNT_W'(TIMEOUT - 1);
  assign err_rdata = owner_q ? 32'h0 : NOP;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (ifu_grant || lsu_grant) begin
          owner_d = lsu_grant;
          last_d  = lsu_grant;
          addr_d  = req_off;
          wen_d   = lsu_grant && lsu_wen;
          wdata_d = lsu_grant ? lsu_wdata : 32'h0;
          wmask_d = lsu_grant ? lsu_wmask : 4'h0;
          cnt_d   = '0;
          if (in_range) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = lsu_grant ? 32'h0 : NOP;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (expired) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = err_rdata;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the expiry cycle still wins over the timeout.
        if (mem_resp_valid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = wen_q ? 32'h0 : mem_rdata;
        end else if (expired) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = err_rdata;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ifu_req_ready  = rst && ifu_grant;
  assign lsu_req_ready  = rst && lsu_grant;

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_addr       = mem_req_valid ? addr_q  : 32'h0;
  assign mem_wen        = mem_req_valid && wen_q;
  assign mem_wdata      = mem_req_valid ? wdata_q : 32'h0;
  assign mem_wmask      = mem_req_valid ? wmask_q : 4'h0;

  assign ifu_resp_valid = (state_q == S_RESP) && !owner_q;
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : 32'h0;
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_valid = (state_q == S_RESP) && owner_q;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : 32'h0;
  assign lsu_resp_err   = lsu_resp_valid && err_q;

endmodule

// File: doc/ysyx_25040118_mem_arb.md
Name: ysyx_25040118_mem_arb

Overview:
- Two-requester arbiter sharing the single NPC memory port between the IFU (instruction fetch) and the LSU (loads/stores).
- Accepts one transaction at a time and range-checks its address against the physical memory window.
- Forwards in-range transactions to the memory port, waits for the response with a timeout, and returns the response to the requester that owns the transaction.
- Out-of-range IFU fetches return NOP (0x00000013) with an error flag.

Parameters:
- MEM_BASE, 32'h80000000, base of the physical memory window.
- MEM_SIZE, 32'h08000000, window size in bytes. An address is in range iff (addr - MEM_BASE) < MEM_SIZE, computed as unsigned 32-bit.
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before an error response is returned.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  one-cycle response pulse to IFU
- ifu_rdata  out  32  fetched instruction
- ifu_resp_err  out  1  range or timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  access address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte enables
- lsu_resp_valid  out  1  one-cycle response pulse to LSU
- lsu_rdata  out  32  load data (0 for stores)
- lsu_resp_err  out  1  range or timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  physical address (addr - MEM_BASE)
- mem_wen  out  1  store flag
- mem_wdata  out  32  store data
- mem_wmask  out  4  byte enables
- mem_resp_valid  in  1  memory response
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (rst=0, asynchronous): state=IDLE, owner=IFU, last_grant=IFU, timeout counter=0, latched request fields=0. All outputs are 0; both req_ready signals are 0 while reset is asserted.
- Reset asserted mid-transaction: the transaction is abandoned silently. No response is issued after reset is released.
- IDLE, ready generation:
  - Ready is combinational and is 1 only for the granted requester, only in IDLE, only when that requester's valid=1.
  - Both valid: grant the requester that was not granted last (round-robin). After reset the LSU wins the first tie.
- IDLE, on handshake (valid & ready):
  - Latch addr/wen/wdata/wmask and set the owner; update last_grant.
  - In range: go to REQ and clear the counter.
  - Out of range: go to RESP with err=1. rdata=0x00000013 if the owner is IFU, else 0. Memory is not touched.
- REQ:
  - mem_req_valid=1 with the latched fields; mem_addr = latched addr - MEM_BASE.
  - mem_req_ready=1 moves to WAIT.
- WAIT:
  - mem_resp_valid=1 captures rdata (forced to 0 if wen), sets err=0, and moves to RESP.
  - A response arriving in the same cycle as mem_req_ready in REQ is not accepted. Memory must respond no earlier than the cycle after acceptance.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When it equals TIMEOUT-1 and no handshake/response occurs this cycle, go to RESP with err=1, rdata=0 (IFU: 0x00000013).
  - A response in the same cycle as the expiry takes priority over the timeout.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle with the registered rdata/err; the other requester sees resp_valid=0.
  - Then go to IDLE.
  - New requests cannot be accepted in RESP.
- Stale responses: mem_resp_valid outside WAIT is ignored.
- Latency:
  - Minimum in-range: handshake at cycle 0, mem_req_valid at cycle 1. With ready at 1 and response at 2, resp_valid is at cycle 3.
  - Out of range: resp_valid at cycle 1.
- Single outstanding transaction. Requester fields may change once ready has been seen.

Test Plan:
- Reset then IFU fetch 0x80000004; mem ready immediately, mem_rdata=0x00100073 one cycle later -> mem_addr=0x00000004; ifu_resp_valid pulse at cycle 3 with rdata 0x00100073, err=0; lsu_resp_valid stays 0.
- IFU and LSU both valid every cycle after reset -> grants alternate LSU, IFU, LSU, IFU; each ready is a single-cycle pulse and only in IDLE.
- LSU store addr 0x80000010, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_wen=1, mem_addr=0x10, mem_wmask=0011; lsu_resp_valid with rdata=0, err=0.
- IFU fetch 0x00001000 (out of range) -> no mem_req_valid; ifu_resp_valid at cycle 1 with rdata 0x00000013, err=1.
- LSU load with memory never responding, TIMEOUT=16 -> lsu_resp_valid after 16 cycles in REQ/WAIT with err=1, rdata=0. A late mem_resp_valid is ignored and the next request is served normally.
- Drop rst low during WAIT -> all outputs 0 immediately (async). After release: no response pulse, state IDLE, and the LSU wins the first tie.
